// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the pipeline stages: opcodes, register index width
// and small helpers for instruction classification and RAW hazard detection.
package id_stage_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [5:0]  OP_B        = 6'b010100;
  localparam logic [5:0]  OP_BL       = 6'b010101;
  localparam logic [5:0]  OP_BEQ      = 6'b010110;
  localparam logic [5:0]  OP_BNE      = 6'b010111;
  localparam logic [5:0]  OP_JIRL     = 6'b010011;
  localparam logic [11:0] OP_3R_GROUP = 12'h001;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic isB;
    logic isBl;
    logic isBeq;
    logic isBne;
    logic isJirl;
    logic is3r;
  } dec_t;

  function automatic dec_t decodeInst(input logic [31:0] inst);
    dec_t d;
    d.isB    = (inst[31:26] == OP_B);
    d.isBl   = (inst[31:26] == OP_BL);
    d.isBeq  = (inst[31:26] == OP_BEQ);
    d.isBne  = (inst[31:26] == OP_BNE);
    d.isJirl = (inst[31:26] == OP_JIRL);
    d.is3r   = (inst[31:20] == OP_3R_GROUP);
    return d;
  endfunction

  // r0 is hardwired to zero, so it never creates a dependency in either direction.
  function automatic logic rawConflict(input reg_idx_t src, input logic used,
                                       input reg_idx_t exDest, input reg_idx_t memDest,
                                       input reg_idx_t wbDest);
    logic hit;
    hit = ((exDest  != '0) && (src == exDest))  ||
          ((memDest != '0) && (src == memDest)) ||
          ((wbDest  != '0) && (src == wbDest));
    return used && (src != '0) && hit;
  endfunction

endpackage

// File: rtl/id_stage_br_resolve.sv
// Branch resolution for the decode stage: evaluates the branch condition and
// computes the redirect target for b/bl/beq/bne/jirl.
module id_br_resolve
  import id_stage_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] offs16_i,
  input  logic [31:0] offs26_i,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  output logic        cond_o,
  output logic [31:0] target_o
);

  logic srcEqual;

  assign srcEqual = (rdata1_i == rdata2_i);

  // Non-branch opcodes resolve to "not taken" with a zero target.
  always_comb begin
    cond_o   = 1'b0;
    target_o = 32'h0;
    case (op_i)
      OP_B, OP_BL: begin
        cond_o   = 1'b1;
        target_o = pc_i + offs26_i;
      end
      OP_BEQ: begin
        cond_o   = srcEqual;
        target_o = pc_i + offs16_i;
      end
      OP_BNE: begin
        cond_o   = ~srcEqual;
        target_o = pc_i + offs16_i;
      end
      OP_JIRL: begin
        cond_o   = 1'b1;
        target_o = rdata1_i + offs16_i;
      end
      default: begin
        cond_o   = 1'b0;
        target_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: holds one instruction, reads sources, detects RAW
// hazards against downstream stages and resolves branches for fetch redirect.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 if_to_id_valid,
  input  logic [31:0]          if_inst,
  input  logic [31:0]          if_pc,
  output logic                 id_allowin,
  output logic                 br_taken,
  output logic [31:0]          br_target,
  output logic [REG_IDX_W-1:0] rf_raddr1,
  output logic [REG_IDX_W-1:0] rf_raddr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic [REG_IDX_W-1:0] ex_dest,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic [REG_IDX_W-1:0] wb_dest,
  input  logic                 ex_allowin,
  output logic                 id_to_ex_valid,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_inst,
  output logic [31:0]          id_src1,
  output logic [31:0]          id_src2,
  output logic [REG_IDX_W-1:0] id_dest
);

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  dec_t        dec;
  logic        src1Used, src2Used;
  logic        hazard, idReadyGo;
  logic [31:0] offs16, offs26;
  logic        brCond;
  logic [31:0] brTargetRaw;

  assign dec = decodeInst(id_inst_q);

  assign rf_raddr1 = id_inst_q[9:5];
  assign rf_raddr2 = (dec.isBeq | dec.isBne) ? id_inst_q[4:0] : id_inst_q[14:10];

  assign src1Used = ~(dec.isB | dec.isBl);
  assign src2Used = dec.isBeq | dec.isBne | dec.is3r;

  assign hazard = rawConflict(rf_raddr1, src1Used, ex_dest, mem_dest, wb_dest) |
                  rawConflict(rf_raddr2, src2Used, ex_dest, mem_dest, wb_dest);

  assign idReadyGo      = ~hazard;
  assign id_allowin     = ~id_valid_q | (idReadyGo & ex_allowin);
  assign id_to_ex_valid = id_valid_q & idReadyGo;

  assign offs16 = {{14{id_inst_q[25]}}, id_inst_q[25:10], 2'b00};
  assign offs26 = {{4{id_inst_q[9]}}, id_inst_q[9:0], id_inst_q[25:10], 2'b00};

  id_br_resolve u_br_resolve (
    .op_i     (id_inst_q[31:26]),
    .pc_i     (id_pc_q),
    .offs16_i (offs16),
    .offs26_i (offs26),
    .rdata1_i (rf_rdata1),
    .rdata2_i (rf_rdata2),
    .cond_o   (brCond),
    .target_o (brTargetRaw)
  );

  // A branch only redirects once it actually moves on to execute, so it fires exactly once.
  assign br_taken  = id_valid_q & idReadyGo & ex_allowin & brCond;
  assign br_target = br_taken ? brTargetRaw : 32'h0;

  assign id_src1 = rf_rdata1;
  assign id_src2 = rf_rdata2;

  always_comb begin
    id_dest = id_inst_q[4:0];
    if (dec.isBl) begin
      id_dest = 5'd1;
    end else if (dec.isB | dec.isBeq | dec.isBne) begin
      id_dest = 5'd0;
    end
  end

  assign id_pc   = id_pc_q;
  assign id_inst = id_inst_q;

  // The wrong-path instruction arriving alongside a taken branch is captured but invalidated.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (id_allowin) begin
      id_valid_d = if_to_id_valid & ~br_taken;
      if (if_to_id_valid) begin
        id_pc_d   = if_pc;
        id_inst_d = if_inst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push expected branch and
// issue records; a monitor pops and compares them whenever the stage presents output.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_to_id_valid;
  logic [31:0] if_inst, if_pc;
  logic        id_allowin, br_taken;
  logic [31:0] br_target;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic        ex_allowin;
  logic        id_to_ex_valid;
  logic [31:0] id_pc, id_inst, id_src1, id_src2;
  logic [4:0]  id_dest;

  logic [31:0] regFile [32];

  typedef struct {
    logic        isBranch;
    logic [31:0] pc, inst, target, src1, src2;
    logic [4:0]  dest, ra1, ra2;
  } exp_t;

  exp_t scoreQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = regFile[rf_raddr1];
  assign rf_rdata2 = regFile[rf_raddr2];

  id_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .if_to_id_valid (if_to_id_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .id_allowin     (id_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .ex_dest        (ex_dest),
    .mem_dest       (mem_dest),
    .wb_dest        (wb_dest),
    .ex_allowin     (ex_allowin),
    .id_to_ex_valid (id_to_ex_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_src1        (id_src1),
    .id_src2        (id_src2),
    .id_dest        (id_dest)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic pushIssue(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] dest,
                           input logic [4:0] ra1, input logic [4:0] ra2);
    exp_t e;
    e.isBranch = 1'b0; e.pc = pc; e.inst = inst; e.target = 32'h0;
    e.dest = dest; e.ra1 = ra1; e.ra2 = ra2;
    e.src1 = regFile[ra1]; e.src2 = regFile[ra2];
    scoreQ.push_back(e);
  endtask

  task automatic pushBranch(input logic [31:0] target);
    exp_t e;
    e.isBranch = 1'b1; e.pc = 32'h0; e.inst = 32'h0; e.target = target;
    e.dest = 5'd0; e.ra1 = 5'd0; e.ra2 = 5'd0; e.src1 = 32'h0; e.src2 = 32'h0;
    scoreQ.push_back(e);
  endtask

  // Offers one instruction and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst);
    int   n = 0;
    logic acc = 1'b0;
    if_to_id_valid = 1'b1;
    if_pc = pc;
    if_inst = inst;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = id_allowin;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("offer_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    if_to_id_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (br_taken) begin
          if (scoreQ.size() == 0) begin
            checkOutput("unexpected_br_taken", 32'(br_taken), 32'd0);
          end else begin
            e = scoreQ.pop_front();
            checkOutput("br_kind", 32'(e.isBranch), 32'd1);
            checkOutput("br_target", br_target, e.target);
          end
        end
        if (id_to_ex_valid && ex_allowin) begin
          if (scoreQ.size() == 0) begin
            checkOutput("unexpected_issue", 32'(id_to_ex_valid), 32'd0);
          end else begin
            e = scoreQ.pop_front();
            checkOutput("issue_kind", 32'(e.isBranch), 32'd0);
            checkOutput("issue_pc", id_pc, e.pc);
            checkOutput("issue_inst", id_inst, e.inst);
            checkOutput("issue_dest", 32'(id_dest), 32'(e.dest));
            checkOutput("issue_raddr1", 32'(rf_raddr1), 32'(e.ra1));
            checkOutput("issue_raddr2", 32'(rf_raddr2), 32'(e.ra2));
            checkOutput("issue_src1", id_src1, e.src1);
            checkOutput("issue_src2", id_src2, e.src2);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regFile[i] = 32'h100 + i;
    resetn = 1'b0; if_to_id_valid = 1'b0; if_pc = 32'h0; if_inst = 32'h0;
    ex_dest = 5'd0; mem_dest = 5'd0; wb_dest = 5'd0; ex_allowin = 1'b1;
    fork
      monitorLoop();
    join_none
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_allowin", 32'(id_allowin), 32'd1);
    checkOutput("rst_to_ex_valid", 32'(id_to_ex_valid), 32'd0);
    checkOutput("rst_br_taken", 32'(br_taken), 32'd0);
    checkOutput("rst_br_target", br_target, 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    @(posedge clk); #1;

    $display("[TB] 3R add r1,r2,r3");
    regFile[2] = 32'h11; regFile[3] = 32'h22;
    pushIssue(32'h1C000000, 32'h00100C41, 5'd1, 5'd2, 5'd3);
    applyStimulus(32'h1C000000, 32'h00100C41);
    idleCycles(2);

    $display("[TB] beq taken with wrong-path fetch");
    regFile[1] = 32'd5; regFile[2] = 32'd5;
    pushBranch(32'h1C000018);
    pushIssue(32'h1C000010, 32'h58000822, 5'd0, 5'd1, 5'd2);
    applyStimulus(32'h1C000010, 32'h58000822);
    applyStimulus(32'h1C000014, 32'h00100C41);
    if_to_id_valid = 1'b0;
    @(negedge clk);
    checkOutput("wrong_path_cancel", 32'(id_to_ex_valid), 32'd0);
    @(posedge clk); #1;

    $display("[TB] beq not taken then next instruction");
    regFile[2] = 32'd6;
    pushIssue(32'h1C000020, 32'h58000822, 5'd0, 5'd1, 5'd2);
    pushIssue(32'h1C000024, 32'h00100C41, 5'd1, 5'd2, 5'd3);
    applyStimulus(32'h1C000020, 32'h58000822);
    applyStimulus(32'h1C000024, 32'h00100C41);
    idleCycles(2);

    $display("[TB] ex_dest hazard on rj");
    pushIssue(32'h1C000030, 32'h00101486, 5'd6, 5'd4, 5'd5);
    applyStimulus(32'h1C000030, 32'h00101486);
    ex_dest = 5'd4;
    if_to_id_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("ex_hazard_allowin", 32'(id_allowin), 32'd0);
      checkOutput("ex_hazard_to_ex", 32'(id_to_ex_valid), 32'd0);
      @(posedge clk); #1;
    end
    ex_dest = 5'd0;
    idleCycles(2);

    $display("[TB] r0 sources never stall");
    pushIssue(32'h1C000034, 32'h00100007, 5'd7, 5'd0, 5'd0);
    applyStimulus(32'h1C000034, 32'h00100007);
    if_to_id_valid = 1'b0;
    @(negedge clk);
    checkOutput("r0_allowin", 32'(id_allowin), 32'd1);
    @(posedge clk); #1;
    idleCycles(1);

    $display("[TB] wb_dest hazard on rk");
    pushIssue(32'h1C000038, 32'h00102408, 5'd8, 5'd0, 5'd9);
    applyStimulus(32'h1C000038, 32'h00102408);
    wb_dest = 5'd9;
    if_to_id_valid = 1'b0;
    @(negedge clk);
    checkOutput("wb_hazard_allowin", 32'(id_allowin), 32'd0);
    @(posedge clk); #1;
    wb_dest = 5'd0;
    idleCycles(2);

    $display("[TB] jirl with mem_dest hazard");
    regFile[3] = 32'h1C000100;
    pushBranch(32'h1C0000FC);
    pushIssue(32'h1C000040, 32'h4FFFFC61, 5'd1, 5'd3, 5'd31);
    applyStimulus(32'h1C000040, 32'h4FFFFC61);
    mem_dest = 5'd3;
    if_to_id_valid = 1'b0;
    @(negedge clk);
    checkOutput("jirl_stall_br", 32'(br_taken), 32'd0);
    checkOutput("jirl_stall_allowin", 32'(id_allowin), 32'd0);
    @(posedge clk); #1;
    mem_dest = 5'd0;
    idleCycles(2);

    $display("[TB] bl backwards and bne taken");
    pushBranch(32'h1C0000FC);
    pushIssue(32'h1C000100, 32'h57FFFFFF, 5'd1, 5'd31, 5'd31);
    applyStimulus(32'h1C000100, 32'h57FFFFFF);
    idleCycles(2);
    regFile[1] = 32'd5; regFile[2] = 32'd6;
    pushBranch(32'h1C0001F0);
    pushIssue(32'h1C000200, 32'h5FFFF022, 5'd0, 5'd1, 5'd2);
    applyStimulus(32'h1C000200, 32'h5FFFF022);
    idleCycles(2);

    $display("[TB] b held by ex backpressure");
    pushBranch(32'h1C000180);
    pushIssue(32'h1C000080, 32'h50010000, 5'd0, 5'd0, 5'd0);
    applyStimulus(32'h1C000080, 32'h50010000);
    ex_allowin = 1'b0;
    if_pc = 32'h1C000084; if_inst = 32'h00100C41;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_br_taken", 32'(br_taken), 32'd0);
      checkOutput("bp_id_pc", id_pc, 32'h1C000080);
      checkOutput("bp_allowin", 32'(id_allowin), 32'd0);
      @(posedge clk); #1;
    end
    ex_allowin = 1'b1;
    @(posedge clk); #1;
    if_to_id_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_wrong_path_cancel", 32'(id_to_ex_valid), 32'd0);
    checkOutput("bp_br_once", 32'(br_taken), 32'd0);
    @(posedge clk); #1;

    $display("[TB] reset during held branch");
    applyStimulus(32'h1C000300, 32'h50010000);
    ex_allowin = 1'b0;
    if_to_id_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    ex_allowin = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold_to_ex", 32'(id_to_ex_valid), 32'd0);
    checkOutput("rst_hold_br", 32'(br_taken), 32'd0);
    checkOutput("rst_hold_allowin", 32'(id_allowin), 32'd1);
    checkOutput("rst_hold_pc", id_pc, 32'h0);
    checkOutput("rst_hold_inst", id_inst, 32'h0);
    idleCycles(3);

    checkOutput("queue_empty", 32'(scoreQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 if_to_id_valid  in  1  fetch stage offers an instruction this cycle.
REQ-004 if_inst  in  32  offered instruction word; if_pc  in  32  its PC.
REQ-005 id_allowin  out  1  decode can accept an instruction this cycle.
REQ-006 br_taken  out  1  redirect fetch this cycle; br_target  out  32  redirect PC.
REQ-007 rf_raddr1, rf_raddr2  out  5  register-file read addresses; rf_rdata1, rf_rdata2  in  32  combinational read data.
REQ-008 ex_dest, mem_dest, wb_dest  in  5  destination register of the instruction in each downstream stage; 0 = none.
REQ-009 ex_allowin  in  1  execute stage can accept.
REQ-010 id_to_ex_valid  out  1; id_pc, id_inst, id_src1, id_src2  out  32; id_dest  out  5.

Function
REQ-011 Handshake: id_ready_go = ~hazard; id_allowin = ~id_valid | (id_ready_go & ex_allowin); id_to_ex_valid = id_valid & id_ready_go.
REQ-012 Capture: when id_allowin & if_to_id_valid, id_pc/id_inst load if_pc/if_inst at the edge; otherwise hold.
REQ-013 Valid: when id_allowin, id_valid <= if_to_id_valid & ~br_taken (cancels the wrong-path instruction arriving the same cycle as a taken branch); otherwise hold.
REQ-014 Decode on op = id_inst[31:26]: b 010100, bl 010101, beq 010110, bne 010111, jirl 010011.
REQ-015 rf_raddr1 = id_inst[9:5] (rj); rf_raddr2 = id_inst[4:0] (rd) for beq/bne, else id_inst[14:10] (rk).
REQ-016 id_src1 = rf_rdata1, id_src2 = rf_rdata2, combinational.
REQ-017 id_dest = 1 for bl; 0 for b/beq/bne; id_inst[4:0] otherwise (jirl included).
REQ-018 Offsets: offs16 = SignExt32({id_inst[25:10],2'b00}); offs26 = SignExt32({id_inst[9:0],id_inst[25:10],2'b00}).
REQ-019 Targets: b/bl -> id_pc+offs26; beq/bne -> id_pc+offs16; jirl -> rf_rdata1+offs16; 32-bit modular add, carry discarded.
REQ-020 Condition: b/bl/jirl always; beq when rf_rdata1==rf_rdata2; bne when unequal.
REQ-021 br_taken = id_valid & id_ready_go & ex_allowin & condition; asserted exactly one cycle per taken branch; br_target is don't-care when br_taken=0 and is driven to 0.
REQ-022 Source use: rj used by all except b/bl; second source used by beq/bne and by 3R group (id_inst[31:20]==12'h001).
REQ-023 Hazard: any used, nonzero source address equal to any nonzero ex_dest/mem_dest/wb_dest; r0 never hazards.
REQ-024 Stall: hazard holds id_valid, id_pc, id_inst; id_to_ex_valid=0, br_taken=0, id_allowin=0.
REQ-025 Backpressure: ex_allowin=0 with id_valid=1 holds all state; br_taken=0.
REQ-026 Simultaneous taken branch and incoming fetch: incoming captured but id_valid becomes 0.

Reset
REQ-027 While resetn=0 at an edge: id_valid<=0, id_pc<=0, id_inst<=0.
REQ-028 Outputs after reset: id_to_ex_valid=0, br_taken=0, br_target=0, id_allowin=1.
REQ-029 Reset mid-stall or mid-branch discards the held instruction; no br_taken in the following cycle.

Structure
REQ-030 Opcode constants (b, bl, beq, bne, jirl, 3R group) and the 5-bit register-index width live in a shared package used by all stages.
REQ-031 One combinational sub-module id_br_resolve computes condition and br_target from op, id_pc, offsets and rf_rdata1/2.

Verification
REQ-032 Reset then if_pc=0x1C000000, if_inst=0x00100C41 (3R, rj=2, rk=3), ex_allowin=1 -> next cycle id_to_ex_valid=1, rf_raddr1=2, rf_raddr2=3, id_dest=1.
REQ-033 id_inst=beq r1,r2,+8 at pc 0x1C000010 with rf_rdata1=rf_rdata2=5 -> br_taken=1 one cycle, br_target=0x1C000018; instruction offered that cycle never reaches id_to_ex_valid.
REQ-034 Same beq with rf_rdata1=5, rf_rdata2=6 -> br_taken=0, next offered instruction accepted normally.
REQ-035 id_inst uses rj=4 with ex_dest=4 for 2 cycles, then 0 -> id_allowin=0 and id_to_ex_valid=0 both cycles, issue on third cycle; ex_dest=0 with rj=0 never stalls.
REQ-036 jirl rd=1, rj=3, offs16 field=0xFFFF, rf_rdata1=0x1C000100 -> br_target=0x1C0000FC, id_dest=1.
REQ-037 ex_allowin=0 while taken b pending for 3 cycles -> br_taken=0 and id_pc held; asserts once when ex_allowin=1; resetn=0 mid-hold -> id_valid=0 next cycle.
